// File: rtl/image_loader.sv
// Copies WORDS words from a synchronous image ROM into frame RAM, one word per clock, with hold stalls.
// Define IMAGE_LOADER_CHECKSUM_EN to build a running checksum of the written words.
module image_loader #(
    parameter int unsigned WORDS    = 4096,
    parameter logic [31:0] ROM_BASE = 32'd0,
    parameter logic [31:0] RAM_BASE = 32'd0,
    parameter int unsigned ROM_LAT  = 1
) (
    input  logic        clock_50,
    input  logic        reset,
    input  logic        start,
    input  logic        hold,
    output logic [31:0] rom_address,
    input  logic [31:0] rom_data,
    output logic [31:0] ram_address,
    output logic        ram_we,
    output logic [31:0] ram_wd,
    output logic        busy,
    output logic        done,
    output logic [31:0] checksum
);

    typedef enum logic [1:0] {
        IDLE,
        COPY,
        DRAIN,
        DONE
    } state_t;

    localparam logic [31:0] LAST_K = 32'(WORDS - 1);
    localparam int          HEAD   = int'(ROM_LAT) - 1;

    state_t      state;
    state_t      state_next;
    logic [31:0] k;
    logic        issue;
    logic        launch;
    logic        upstream_empty;

    logic        pipe_valid [ROM_LAT];
    logic [31:0] pipe_k     [ROM_LAT];

    // Only the head stage may still hold a read once everything behind it is empty.
    always_comb begin
        upstream_empty = 1'b1;
        for (int i = 0; i < HEAD; i++) begin
            if (pipe_valid[i]) begin
                upstream_empty = 1'b0;
            end
        end
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        launch     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = COPY;
                    launch     = 1'b1;
                end
            end
            COPY: begin
                if (!hold) begin
                    issue = 1'b1;
                    if (k == LAST_K) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (upstream_empty) begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_50) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock_50) begin
        if (reset) begin
            k <= '0;
        end else if (launch) begin
            k <= '0;
        end else if (issue) begin
            k <= k + 32'd1;
        end
    end

    // Each stage tracks one ROM read in flight; a stalled clock injects an empty slot.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            for (int i = 0; i < int'(ROM_LAT); i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_k[i]     <= '0;
            end
        end else begin
            pipe_valid[0] <= issue;
            pipe_k[0]     <= k;
            for (int i = 1; i < int'(ROM_LAT); i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_k[i]     <= pipe_k[i-1];
            end
        end
    end

    assign rom_address = ROM_BASE + k;
    assign ram_we      = pipe_valid[HEAD];
    assign ram_address = RAM_BASE + pipe_k[HEAD];
    assign ram_wd      = rom_data;
    assign busy        = (state == COPY) || (state == DRAIN);
    assign done        = (state == DONE);

`ifdef IMAGE_LOADER_CHECKSUM_EN
    logic [31:0] sum;

    always_ff @(posedge clock_50) begin
        if (reset) begin
            sum <= '0;
        end else if (launch) begin
            sum <= '0;
        end else if (ram_we) begin
            sum <= sum + rom_data;
        end
    end

    assign checksum = sum;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_image_loader.sv
// Scoreboard bench for image_loader: two instances (latency 1 and 2, one with ROM address wrap)
// share start/hold/reset; expected writes come from a per-edge transfer model.
module tb_image_loader;

    localparam int          WORDS_A    = 4;
    localparam int          LAT_A      = 1;
    localparam logic [31:0] ROM_BASE_A = 32'h0000_0000;
    localparam logic [31:0] RAM_BASE_A = 32'h0000_0000;
    localparam int          WORDS_B    = 3;
    localparam int          LAT_B      = 2;
    localparam logic [31:0] ROM_BASE_B = 32'hFFFF_FFFE;
    localparam logic [31:0] RAM_BASE_B = 32'h0000_0100;
    localparam int          MAXN       = 64;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } write_t;

    logic clock_50 = 1'b0;
    logic reset    = 1'b1;
    logic start    = 1'b0;
    logic hold     = 1'b0;

    logic [31:0] rom_address_a, rom_data_a, ram_address_a, ram_wd_a, checksum_a;
    logic        ram_we_a, busy_a, done_a;
    logic [31:0] rom_address_b, rom_data_b, ram_address_b, ram_wd_b, checksum_b;
    logic        ram_we_b, busy_b, done_b;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    write_t q_a[$];
    write_t q_b[$];
    bit     hplan [MAXN+1];
    int     iss_a [MAXN+1];
    int     iss_b [MAXN+1];
    int     last_a, dn_a, last_b, dn_b;
    logic [31:0] sum_a, sum_b;
    logic [31:0] rom_seed = 32'h0;
    logic [31:0] rom_a_q, rom_b_q1, rom_b_q2;

    always #5 clock_50 = ~clock_50;

    always @(posedge clock_50) cyc <= cyc + 1;

    function automatic logic [31:0] rom_fn(input logic [31:0] a, input logic [31:0] seed);
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    function automatic logic [31:0] ck_model(input logic [31:0] s);
`ifdef IMAGE_LOADER_CHECKSUM_EN
        return s;
`else
        return 32'h0;
`endif
    endfunction

    // Synchronous ROM models with the read latency each instance expects.
    always @(posedge clock_50) begin
        rom_a_q  <= rom_fn(rom_address_a, rom_seed);
        rom_b_q1 <= rom_fn(rom_address_b, rom_seed);
        rom_b_q2 <= rom_b_q1;
    end

    assign rom_data_a = rom_a_q;
    assign rom_data_b = rom_b_q2;

    image_loader #(
        .WORDS(WORDS_A), .ROM_BASE(ROM_BASE_A), .RAM_BASE(RAM_BASE_A), .ROM_LAT(LAT_A)
    ) dut_a (
        .clock_50(clock_50), .reset(reset), .start(start), .hold(hold),
        .rom_address(rom_address_a), .rom_data(rom_data_a),
        .ram_address(ram_address_a), .ram_we(ram_we_a), .ram_wd(ram_wd_a),
        .busy(busy_a), .done(done_a), .checksum(checksum_a)
    );

    image_loader #(
        .WORDS(WORDS_B), .ROM_BASE(ROM_BASE_B), .RAM_BASE(RAM_BASE_B), .ROM_LAT(LAT_B)
    ) dut_b (
        .clock_50(clock_50), .reset(reset), .start(start), .hold(hold),
        .rom_address(rom_address_b), .rom_data(rom_data_b),
        .ram_address(ram_address_b), .ram_we(ram_we_b), .ram_wd(ram_wd_b),
        .busy(busy_b), .done(done_b), .checksum(checksum_b)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    always @(negedge clock_50) begin
        if (ram_we_a === 1'b1) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL A unexpected write: got addr 0x%08h data 0x%08h, expected no write (cycle %0d)",
                         ram_address_a, ram_wd_a, cyc);
            end else begin
                write_t e;
                e = q_a.pop_front();
                checkOutput("A write cycle", 32'(cyc), 32'(e.cyc));
                checkOutput("A write address", ram_address_a, e.addr);
                checkOutput("A write data", ram_wd_a, e.data);
            end
        end
    end

    always @(negedge clock_50) begin
        if (ram_we_b === 1'b1) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL B unexpected write: got addr 0x%08h data 0x%08h, expected no write (cycle %0d)",
                         ram_address_b, ram_wd_b, cyc);
            end else begin
                write_t e;
                e = q_b.pop_front();
                checkOutput("B write cycle", 32'(cyc), 32'(e.cyc));
                checkOutput("B write address", ram_address_b, e.addr);
                checkOutput("B write data", ram_wd_b, e.data);
            end
        end
    end

    // Edge-by-edge transfer model: an unheld edge in the copy phase moves one word.
    task automatic plan_copy(input bit sel_b, input int e0, input int cut,
                             output int last_n, output int done_n, output logic [31:0] sum);
        int          words, lat, issued, wcyc;
        logic [31:0] rbase, wbase, data;
        words  = sel_b ? WORDS_B : WORDS_A;
        lat    = sel_b ? LAT_B : LAT_A;
        rbase  = sel_b ? ROM_BASE_B : ROM_BASE_A;
        wbase  = sel_b ? RAM_BASE_B : RAM_BASE_A;
        issued = 0;
        sum    = '0;
        last_n = 0;
        if (sel_b) iss_b[0] = 0; else iss_a[0] = 0;
        for (int n = 1; n <= MAXN; n++) begin
            if (issued < words && !hplan[n]) begin
                wcyc = e0 + n - 1 + lat;
                data = rom_fn(rbase + 32'(issued), rom_seed);
                if (cut == 0 || wcyc < cut) begin
                    if (sel_b) q_b.push_back('{wbase + 32'(issued), data, wcyc});
                    else       q_a.push_back('{wbase + 32'(issued), data, wcyc});
                    sum += data;
                end
                issued++;
                if (issued == words) last_n = n;
            end
            if (sel_b) iss_b[n] = issued; else iss_a[n] = issued;
        end
        done_n = last_n + lat;
    endtask

    task automatic check_step(input int n);
        if (n < last_a) checkOutput("A rom_address", rom_address_a, ROM_BASE_A + 32'(iss_a[n]));
        checkOutput("A busy", 32'(busy_a), 32'(n < dn_a));
        checkOutput("A done", 32'(done_a), 32'(n >= dn_a));
        if (n == 0) checkOutput("A checksum cleared", checksum_a, 32'h0);
        if (n >= dn_a) checkOutput("A checksum final", checksum_a, ck_model(sum_a));
        if (n < last_b) checkOutput("B rom_address", rom_address_b, ROM_BASE_B + 32'(iss_b[n]));
        checkOutput("B busy", 32'(busy_b), 32'(n < dn_b));
        checkOutput("B done", 32'(done_b), 32'(n >= dn_b));
        if (n == 0) checkOutput("B checksum cleared", checksum_b, 32'h0);
        if (n >= dn_b) checkOutput("B checksum final", checksum_b, ck_model(sum_b));
    endtask

    task automatic check_idle(input string tag);
        checkOutput({tag, " A busy"}, 32'(busy_a), 32'h0);
        checkOutput({tag, " A done"}, 32'(done_a), 32'h0);
        checkOutput({tag, " A ram_we"}, 32'(ram_we_a), 32'h0);
        checkOutput({tag, " B busy"}, 32'(busy_b), 32'h0);
        checkOutput({tag, " B done"}, 32'(done_b), 32'h0);
        checkOutput({tag, " B ram_we"}, 32'(ram_we_b), 32'h0);
    endtask

    // One full copy starting at the next edge; start_level keeps start high while both are busy.
    task automatic applyStimulus(input bit use_hold, input bit start_level, input logic [31:0] seed);
        int e0, min_dn, end_n;
        rom_seed = seed;
        for (int n = 0; n <= MAXN; n++) begin
            hplan[n] = use_hold && n >= 1 && n <= 40 && ($urandom_range(0, 2) == 0);
        end
        e0 = cyc + 1;
        plan_copy(1'b0, e0, 0, last_a, dn_a, sum_a);
        plan_copy(1'b1, e0, 0, last_b, dn_b, sum_b);
        min_dn = (dn_a < dn_b) ? dn_a : dn_b;
        end_n  = ((dn_a > dn_b) ? dn_a : dn_b) + 2;
        start = 1'b1;
        hold  = 1'($urandom_range(0, 1));
        @(negedge clock_50);
        check_step(0);
        for (int n = 1; n <= end_n; n++) begin
            hold  = hplan[n];
            start = start_level && (n <= min_dn);
            @(negedge clock_50);
            check_step(n);
        end
        start = 1'b0;
        hold  = 1'b0;
        checkOutput("A writes outstanding", 32'(q_a.size()), 32'h0);
        checkOutput("B writes outstanding", 32'(q_b.size()), 32'h0);
    endtask

    task automatic run_reset_mid_copy(input logic [31:0] seed);
        int e0;
        rom_seed = seed;
        for (int n = 0; n <= MAXN; n++) hplan[n] = 1'b0;
        e0 = cyc + 1;
        plan_copy(1'b0, e0, e0 + 4, last_a, dn_a, sum_a);
        plan_copy(1'b1, e0, e0 + 4, last_b, dn_b, sum_b);
        start = 1'b1;
        @(negedge clock_50);
        start = 1'b0;
        repeat (3) @(negedge clock_50);
        reset = 1'b1;
        @(negedge clock_50);
        check_idle("mid-copy reset");
        checkOutput("reset A rom_address", rom_address_a, ROM_BASE_A);
        checkOutput("reset A ram_address", ram_address_a, RAM_BASE_A);
        checkOutput("reset A checksum", checksum_a, 32'h0);
        checkOutput("reset B rom_address", rom_address_b, ROM_BASE_B);
        checkOutput("reset B ram_address", ram_address_b, RAM_BASE_B);
        checkOutput("reset B checksum", checksum_b, 32'h0);
        start = 1'b1;
        @(negedge clock_50);
        check_idle("start with reset");
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            hold = 1'($urandom_range(0, 1));
            @(negedge clock_50);
            check_idle("after reset");
        end
        hold = 1'b0;
        checkOutput("A writes outstanding after reset", 32'(q_a.size()), 32'h0);
        checkOutput("B writes outstanding after reset", 32'(q_b.size()), 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        hold  = 1'b0;
        repeat (3) @(negedge clock_50);
        check_idle("reset");
        checkOutput("reset A rom_address", rom_address_a, ROM_BASE_A);
        checkOutput("reset A ram_address", ram_address_a, RAM_BASE_A);
        checkOutput("reset A ram_wd", ram_wd_a, rom_data_a);
        checkOutput("reset A checksum", checksum_a, 32'h0);
        checkOutput("reset B rom_address", rom_address_b, ROM_BASE_B);
        checkOutput("reset B ram_address", ram_address_b, RAM_BASE_B);
        checkOutput("reset B checksum", checksum_b, 32'h0);
        reset = 1'b0;
        hold  = 1'b1;
        @(negedge clock_50);
        check_idle("idle");
        hold = 1'b0;

        applyStimulus(1'b0, 1'b0, 32'h0000_0000);
        for (int r = 0; r < 3; r++) applyStimulus(1'b1, 1'b0, $urandom);
        applyStimulus(1'b1, 1'b1, $urandom);
        run_reset_mid_copy($urandom);
        applyStimulus(1'b1, 1'b0, $urandom);
        applyStimulus(1'b0, 1'b1, $urandom);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, expected to have finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
